// File: rtl/ppu_pkg.sv
// Shared PPU definitions: PPUState encoding and default scanline/frame timing.
// Used by the timing generator, fetcher and pixel FIFO.
package ppu_pkg;

    typedef enum logic [1:0] {
        PPU_HBLANK = 2'd0,
        PPU_VBLANK = 2'd1,
        PPU_OAM    = 2'd2,
        PPU_DRAW   = 2'd3
    } ppu_state_e;

    localparam int DEF_DOTS_PER_LINE = 456;
    localparam int DEF_OAM_DOTS      = 80;
    localparam int DEF_VIS_LINES     = 144;
    localparam int DEF_TOTAL_LINES   = 154;
    localparam int DEF_VIS_WIDTH     = 160;

endpackage

// File: rtl/ppu_dot_counter.sv
// Dot-within-line and line-within-frame counter pair with wrap strobes.
// clr_in returns both counters to 0; adv_in advances by one dot.
module ppu_dot_counter import ppu_pkg::*; #(
    parameter int DOTS_PER_LINE = DEF_DOTS_PER_LINE,
    parameter int TOTAL_LINES   = DEF_TOTAL_LINES,
    localparam int DW           = $clog2(DOTS_PER_LINE)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          clr_in,
    input  logic          adv_in,
    output logic [DW-1:0] dot_out,
    output logic [7:0]    line_out,
    output logic          dot_wrap_out,
    output logic          line_wrap_out
);

    localparam logic [DW-1:0] DOT_LAST  = DW'(DOTS_PER_LINE - 1);
    localparam logic [7:0]    LINE_LAST = 8'(TOTAL_LINES - 1);

    logic [DW-1:0] dot_q, dot_d;
    logic [7:0]    line_q, line_d;

    assign dot_wrap_out  = adv_in & (dot_q == DOT_LAST);
    assign line_wrap_out = dot_wrap_out & (line_q == LINE_LAST);
    assign dot_out       = dot_q;
    assign line_out      = line_q;

    always_comb begin
        dot_d  = dot_q;
        line_d = line_q;
        if (clr_in) begin
            dot_d  = '0;
            line_d = '0;
        end else if (adv_in) begin
            if (dot_wrap_out) begin
                dot_d  = '0;
                line_d = line_wrap_out ? 8'd0 : line_q + 8'd1;
            end else begin
                dot_d = dot_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            dot_q  <= '0;
            line_q <= '0;
        end else begin
            dot_q  <= dot_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/ppu_timing_gen.sv
// PPU scanline/frame timing: mode sequencing, pixel X, LY/LYC and STAT/VBlank pulses.
// Define PPU_LY153_QUIRK_EN to make LY read 0 from dot 4 of the last line.
module ppu_timing_gen import ppu_pkg::*; #(
    parameter int DOTS_PER_LINE = DEF_DOTS_PER_LINE,
    parameter int OAM_DOTS      = DEF_OAM_DOTS,
    parameter int VIS_LINES     = DEF_VIS_LINES,
    parameter int TOTAL_LINES   = DEF_TOTAL_LINES,
    parameter int VIS_WIDTH     = DEF_VIS_WIDTH,
    localparam int XW           = $clog2(VIS_WIDTH + 1),
    localparam int DW           = $clog2(DOTS_PER_LINE)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          lcd_en_in,
    input  logic          pixel_push_in,
    input  logic [7:0]    lyc_in,
    input  logic [3:0]    stat_sel_in,
    output logic [1:0]    mode_out,
    output logic [7:0]    ly_out,
    output logic [XW-1:0] x_out,
    output logic [DW-1:0] dot_out,
    output logic          lyc_eq_out,
    output logic          stat_irq_out,
    output logic          vblank_irq_out,
    output logic          frame_start_out,
    output logic          draw_overrun_out
);

    if (OAM_DOTS + VIS_WIDTH > DOTS_PER_LINE) begin : g_bad_line
        $error("OAM_DOTS + VIS_WIDTH exceeds DOTS_PER_LINE");
    end
    if (VIS_LINES >= TOTAL_LINES) begin : g_bad_vis
        $error("VIS_LINES must be below TOTAL_LINES");
    end
    if (TOTAL_LINES > 256) begin : g_bad_total
        $error("TOTAL_LINES must fit an 8-bit LY");
    end

    localparam logic [7:0]    VIS_L    = 8'(VIS_LINES);
    localparam logic [DW-1:0] OAM_LAST = DW'(OAM_DOTS - 1);
    localparam logic [DW-1:0] DOT_PRE  = DW'(DOTS_PER_LINE - 2);
    localparam logic [XW-1:0] X_LAST   = XW'(VIS_WIDTH - 1);
    localparam logic [XW-1:0] X_DONE   = XW'(VIS_WIDTH);

    ppu_state_e    mode_q, mode_d;
    logic [XW-1:0] x_q, x_d;
    logic [7:0]    ly_q, ly_d, line_nx, line_w;
    logic [DW-1:0] dot_w;
    logic          running_q, running_d, start, adv, dot_wrap, line_wrap;
    logic          lyc_eq_q, lyc_eq_d, stat_or_q, stat_or_d, stat_irq_q, stat_irq_d;
    logic          vblank_q, vblank_d, frame_q, frame_d, overrun_q, overrun_d;

    // The first enabled cycle only arms the generator; counting starts the cycle after.
    assign start = lcd_en_in & ~running_q;
    assign adv   = lcd_en_in & running_q;

    ppu_dot_counter #(
        .DOTS_PER_LINE(DOTS_PER_LINE),
        .TOTAL_LINES  (TOTAL_LINES)
    ) u_dot_counter (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .clr_in       (~lcd_en_in),
        .adv_in       (adv),
        .dot_out      (dot_w),
        .line_out     (line_w),
        .dot_wrap_out (dot_wrap),
        .line_wrap_out(line_wrap)
    );

    always_comb begin
        line_nx = line_w;
        if (!lcd_en_in || start || line_wrap) line_nx = 8'd0;
        else if (dot_wrap)                    line_nx = line_w + 8'd1;
    end

`ifdef PPU_LY153_QUIRK_EN
    localparam logic [7:0] LINE_LAST = 8'(TOTAL_LINES - 1);
    logic [DW-1:0] dot_nx;
    assign dot_nx = (!lcd_en_in || start || dot_wrap) ? '0 : dot_w + DW'(1);
    assign ly_d   = (line_nx == LINE_LAST && dot_nx >= DW'(4)) ? 8'd0 : line_nx;
`else
    assign ly_d   = line_nx;
`endif

    always_comb begin
        mode_d    = mode_q;
        x_d       = x_q;
        overrun_d = overrun_q;
        running_d = lcd_en_in;
        vblank_d  = 1'b0;
        frame_d   = 1'b0;
        if (!lcd_en_in) begin
            mode_d    = PPU_HBLANK;
            x_d       = '0;
            overrun_d = 1'b0;
        end else if (start || dot_wrap) begin
            mode_d   = (line_nx < VIS_L) ? PPU_OAM : PPU_VBLANK;
            x_d      = '0;
            frame_d  = start | line_wrap;
            vblank_d = dot_wrap & (line_nx == VIS_L);
        end else begin
            case (mode_q)
                PPU_OAM:  if (dot_w == OAM_LAST) mode_d = PPU_DRAW;
                PPU_DRAW: if (pixel_push_in) begin
                    if (x_q == X_LAST) begin
                        mode_d = PPU_HBLANK;
                        x_d    = X_DONE;
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
                default: ;
            endcase
        end
        // Flag is raised as the last dot of the line begins while still drawing.
        if (adv && !dot_wrap && dot_w == DOT_PRE && mode_d == PPU_DRAW) overrun_d = 1'b1;
    end

    assign lyc_eq_d   = lcd_en_in & (ly_d == lyc_in);
    assign stat_or_d  = lcd_en_in & ((stat_sel_in[0] & (mode_d == PPU_HBLANK)) |
                                     (stat_sel_in[1] & (mode_d == PPU_VBLANK)) |
                                     (stat_sel_in[2] & (mode_d == PPU_OAM))    |
                                     (stat_sel_in[3] & lyc_eq_d));
    assign stat_irq_d = stat_or_d & ~stat_or_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mode_q     <= PPU_HBLANK;
            x_q        <= '0;
            ly_q       <= '0;
            running_q  <= 1'b0;
            lyc_eq_q   <= 1'b0;
            stat_or_q  <= 1'b0;
            stat_irq_q <= 1'b0;
            vblank_q   <= 1'b0;
            frame_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            x_q        <= x_d;
            ly_q       <= ly_d;
            running_q  <= running_d;
            lyc_eq_q   <= lyc_eq_d;
            stat_or_q  <= stat_or_d;
            stat_irq_q <= stat_irq_d;
            vblank_q   <= vblank_d;
            frame_q    <= frame_d;
            overrun_q  <= overrun_d;
        end
    end

    assign mode_out         = mode_q;
    assign ly_out           = ly_q;
    assign x_out            = x_q;
    assign dot_out          = dot_w;
    assign lyc_eq_out       = lyc_eq_q;
    assign stat_irq_out     = stat_irq_q;
    assign vblank_irq_out   = vblank_q;
    assign frame_start_out  = frame_q;
    assign draw_overrun_out = overrun_q;

endmodule

// File: tb/tb_ppu_timing_gen.sv
// Directed bench for ppu_timing_gen at default timing: line modes, overrun,
// LCD enable restart, STAT blocking, VBlank/frame pulses and async reset.
module tb_ppu_timing_gen;

`ifdef PPU_LY153_QUIRK_EN
    localparam bit QUIRK = 1'b1;
`else
    localparam bit QUIRK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, lcd_en, push;
    logic [7:0] lyc;
    logic [3:0] sel;
    logic [1:0] mode;
    logic [7:0] ly;
    logic [7:0] x;
    logic [8:0] dot;
    logic       lyc_eq, stat_irq, vblank_irq, frame_start, overrun;

    int checks = 0, failures = 0;
    int stat_cnt = 0, vbl_cnt = 0, frm_cnt = 0;

    always #5 clk = ~clk;

    ppu_timing_gen dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .lcd_en_in       (lcd_en),
        .pixel_push_in   (push),
        .lyc_in          (lyc),
        .stat_sel_in     (sel),
        .mode_out        (mode),
        .ly_out          (ly),
        .x_out           (x),
        .dot_out         (dot),
        .lyc_eq_out      (lyc_eq),
        .stat_irq_out    (stat_irq),
        .vblank_irq_out  (vblank_irq),
        .frame_start_out (frame_start),
        .draw_overrun_out(overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (stat_irq === 1'b1)    stat_cnt++;
            if (vblank_irq === 1'b1)  vbl_cnt++;
            if (frame_start === 1'b1) frm_cnt++;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_mode"}, 32'(mode), 0);
        chk({tag, "_ly"}, 32'(ly), 0);
        chk({tag, "_x"}, 32'(x), 0);
        chk({tag, "_dot"}, 32'(dot), 0);
        chk({tag, "_lyceq"}, 32'(lyc_eq), 0);
        chk({tag, "_pulses"}, 32'({stat_irq, vblank_irq, frame_start}), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
    endtask

    initial begin
        rst_n = 1'b0; lcd_en = 1'b0; push = 1'b0; lyc = 8'd0; sel = 4'd0;
        run(3);
        chk_idle("reset");

        // Release reset with LCD enabled: first dot is line 0 dot 0 OAMScan.
        rst_n = 1'b1; lcd_en = 1'b1;
        run(1);
        chk("start_dot", 32'(dot), 0);
        chk("start_ly", 32'(ly), 0);
        chk("start_mode", 32'(mode), 2);
        chk("start_frame", 32'(frame_start), 1);
        chk("start_lyceq", 32'(lyc_eq), 1);
        run(1);
        chk("dot1", 32'(dot), 1);
        chk("dot1_frame", 32'(frame_start), 0);
        run(78);
        chk("dot79_mode", 32'(mode), 2);
        push = 1'b1;
        run(1);
        chk("dot80_mode", 32'(mode), 3);
        chk("dot80_x_oampush_ignored", 32'(x), 0);
        run(80);
        chk("dot160_x", 32'(x), 80);
        run(79);
        chk("dot239_mode", 32'(mode), 3);
        chk("dot239_x", 32'(x), 159);
        run(1);
        chk("dot240_mode", 32'(mode), 0);
        chk("dot240_x", 32'(x), 160);
        run(215);
        chk("dot455_dot", 32'(dot), 455);
        chk("dot455_ly", 32'(ly), 0);
        chk("dot455_x_hold", 32'(x), 160);
        run(1);
        chk("l1_ly", 32'(ly), 1);
        chk("l1_dot", 32'(dot), 0);
        chk("l1_mode", 32'(mode), 2);
        chk("l1_x", 32'(x), 0);
        chk("l1_lyceq", 32'(lyc_eq), 0);

        // Drop LCD enable mid-Draw at LY=50 dot 200.
        run(22544);
        chk("l50_ly", 32'(ly), 50);
        chk("l50_dot", 32'(dot), 200);
        chk("l50_mode", 32'(mode), 3);
        chk("l50_x", 32'(x), 120);
        lcd_en = 1'b0;
        run(1);
        chk_idle("lcdoff");
        lyc = 8'd5; sel = 4'b1001;
        run(2);
        chk_idle("lcdoff_hold");
        lcd_en = 1'b1;
        run(1);
        chk("restart_ly", 32'(ly), 0);
        chk("restart_dot", 32'(dot), 0);
        chk("restart_mode", 32'(mode), 2);
        chk("restart_frame", 32'(frame_start), 1);
        stat_cnt = 0; vbl_cnt = 0; frm_cnt = 0;

        // Line 3: only 100 pixels pushed, Draw overruns the line.
        run(3 * 456 + 80);
        chk("l3_ly", 32'(ly), 3);
        chk("l3_dot80_x", 32'(x), 0);
        run(100);
        chk("l3_x100", 32'(x), 100);
        push = 1'b0;
        run(274);
        chk("l3_dot454_ovr", 32'(overrun), 0);
        run(1);
        chk("l3_dot455_dot", 32'(dot), 455);
        chk("l3_dot455_ovr", 32'(overrun), 1);
        chk("l3_dot455_mode", 32'(mode), 3);
        run(1);
        chk("l4_ly", 32'(ly), 4);
        chk("l4_mode", 32'(mode), 2);
        chk("l4_ovr_sticky", 32'(overrun), 1);
        chk("l4_x", 32'(x), 0);

        // No pushes on line 4 keeps HBlank away, so LYC on line 5 raises STAT.
        stat_cnt = 0;
        run(455);
        chk("l4_no_stat", stat_cnt, 0);
        run(1);
        chk("l5_ly", 32'(ly), 5);
        chk("l5_lyceq", 32'(lyc_eq), 1);
        chk("l5_stat", 32'(stat_irq), 1);
        push = 1'b1;
        run(240);
        chk("l5_hblank", 32'(mode), 0);
        chk("l5_hblank_stat", 32'(stat_irq), 0);
        run(216);
        chk("l6_ly", 32'(ly), 6);
        chk("l5_stat_count", stat_cnt, 1);

        // Remainder of the frame: VBlank entry, LY wrap, 70224-cycle frame.
        run(143 * 456 + 455 - 6 * 456);
        chk("l143_mode", 32'(mode), 0);
        chk("l143_vbl", 32'(vblank_irq), 0);
        run(1);
        chk("l144_ly", 32'(ly), 144);
        chk("l144_dot", 32'(dot), 0);
        chk("l144_mode", 32'(mode), 1);
        chk("l144_vbl", 32'(vblank_irq), 1);
        run(152 * 456 + 454 - (144 * 456 + 1) + 1);
        chk("l152_dot", 32'(dot), 454);
        lyc = 8'd0;
        run(2);
        chk("l153_ly_d0", 32'(ly), 153);
        chk("l153_lyceq_d0", 32'(lyc_eq), 0);
        run(3);
        chk("l153_ly_d3", 32'(ly), 153);
        run(1);
        chk("l153_ly_d4", 32'(ly), QUIRK ? 0 : 153);
        chk("l153_lyceq_d4", 32'(lyc_eq), QUIRK ? 1 : 0);
        run(451);
        chk("l153_dot455", 32'(dot), 455);
        chk("l153_ly_d455", 32'(ly), QUIRK ? 0 : 153);
        run(1);
        chk("wrap_ly", 32'(ly), 0);
        chk("wrap_mode", 32'(mode), 2);
        chk("wrap_frame", 32'(frame_start), 1);
        chk("frame_pulse_count", frm_cnt, 1);
        chk("vblank_pulse_count", vbl_cnt, 1);
        chk("wrap_lyceq", 32'(lyc_eq), 1);

        // Asynchronous reset mid-Draw abandons the line without a pulse.
        run(100);
        chk("pre_rst_mode", 32'(mode), 3);
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        run(2);
        chk_idle("async_rst_hold");
        rst_n = 1'b1;
        run(1);
        chk("rerun_mode", 32'(mode), 2);
        chk("rerun_frame", 32'(frame_start), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ppu_timing_gen.md
PPU_TIMING_GEN -- requirements
Module: ppu_timing_gen

Interface
REQ-001 SHALL have parameter DOTS_PER_LINE, default 456, meaning T-cycles (dots) per scanline.
REQ-002 SHALL have parameter OAM_DOTS, default 80, meaning OAMScan length in dots.
REQ-003 SHALL have parameter VIS_LINES, default 144, meaning visible scanlines.
REQ-004 SHALL have parameter TOTAL_LINES, default 154, meaning scanlines per frame including VBlank.
REQ-005 SHALL have parameter VIS_WIDTH, default 160, meaning pixels pushed per visible line.
REQ-006 SHALL have port clk_in  input  1  dot clock; the block's only clock.
REQ-007 SHALL have port rst_in  input  1  reset; asynchronous, active-low.
REQ-008 SHALL have port lcd_en_in  input  1  LCD enable (LCDC bit 7).
REQ-009 SHALL have port pixel_push_in  input  1  one pixel left the FIFO this cycle.
REQ-010 SHALL have port lyc_in  input  8  LY compare value.
REQ-011 SHALL have port stat_sel_in  input  4  STAT source enables [0]=HBlank [1]=VBlank [2]=OAMScan [3]=LYC.
REQ-012 SHALL have port mode_out  output  2  PPUState (HBlank=0, VBlank=1, OAMScan=2, Draw=3).
REQ-013 SHALL have ports ly_out (8), x_out ($clog2(VIS_WIDTH+1)) and dot_out ($clog2(DOTS_PER_LINE)), all outputs: scanline, pixel X and dot within the line.
REQ-014 SHALL have outputs lyc_eq_out, stat_irq_out, vblank_irq_out, frame_start_out and draw_overrun_out, each 1 bit.

Function
REQ-015 SHALL register every output; no combinational path from inputs to outputs.
REQ-016 Dot counter SHALL increment each cycle while lcd_en_in=1 and wrap from DOTS_PER_LINE-1 to 0.
REQ-017 On dot wrap, ly_out SHALL increment, wrapping from TOTAL_LINES-1 to 0.
REQ-018 Visible line (LY<VIS_LINES): SHALL be OAMScan for dots 0..OAM_DOTS-1, then Draw from dot OAM_DOTS.
REQ-019 Draw SHALL end, going to HBlank on the next edge, on the cycle pixel_push_in=1 with x_out=VIS_WIDTH-1; x_out then reads VIS_WIDTH until the line ends.
REQ-020 x_out SHALL increment only on pixel_push_in=1 in Draw, SHALL ignore pushes in other modes, and SHALL clear to 0 at line start.
REQ-021 Draw length SHALL be variable, since it is set by the push rate; HBlank absorbs the remainder of the line.
REQ-022 If Draw is still active at dot DOTS_PER_LINE-1, the block SHALL force a line wrap and set draw_overrun_out, which stays sticky until reset or lcd_en_in=0.
REQ-023 Lines VIS_LINES..TOTAL_LINES-1 SHALL be VBlank for all dots.
REQ-024 vblank_irq_out SHALL pulse for 1 cycle when entering VBlank (line VIS_LINES, dot 0).
REQ-025 frame_start_out SHALL pulse for 1 cycle at line 0 dot 0, including the first dot after enable.
REQ-026 lyc_eq_out SHALL be (ly_out==lyc_in), re-evaluated every cycle.
REQ-027 stat_irq_out SHALL pulse for 1 cycle on the 0->1 edge of the OR of the enabled sources (STAT blocking); a source change that keeps the OR high SHALL NOT pulse.
REQ-028 lcd_en_in=0 SHALL hold the block in its reset state; lcd_en_in 0->1 SHALL start at line 0, dot 0, OAMScan.

Reset
REQ-029 rst_in=0 SHALL asynchronously force: mode_out=HBlank, ly_out=0, x_out=0, dot_out=0, lyc_eq_out=0, all pulses 0, draw_overrun_out=0, and the STAT OR history cleared.
REQ-030 After reset release with lcd_en_in=1, the first dot SHALL be line 0, dot 0, OAMScan, with frame_start_out pulsed.
REQ-031 Reset asserted mid-line or mid-Draw SHALL abandon the line with no pulse emitted.

Configuration
REQ-032 Macro PPU_LY153_QUIRK_EN defined: on line TOTAL_LINES-1, ly_out SHALL read TOTAL_LINES-1 for dots 0..3, then 0 for the rest of the line, and the LYC compare SHALL use that displayed value.
REQ-033 Macro PPU_LY153_QUIRK_EN undefined: ly_out SHALL read TOTAL_LINES-1 for the whole line.

Structure
REQ-034 The PPUState enum and default timing constants SHALL live in package ppu_pkg, shared with the fetcher and FIFO.
REQ-035 The line/dot counter pair SHALL be sub-module ppu_dot_counter (parameters DOTS_PER_LINE and TOTAL_LINES; outputs dot, line and wrap strobes).
REQ-036 Parameter checks SHALL be elaborated: OAM_DOTS+VIS_WIDTH <= DOTS_PER_LINE, VIS_LINES < TOTAL_LINES, and TOTAL_LINES <= 256.

Verification
REQ-037 Push every cycle from dot 80 -> Draw occupies dots 80..239, HBlank from dot 240, LY=1 at the cycle after dot 455.
REQ-038 Run one full frame at defaults -> vblank_irq_out pulses once at LY=144 dot 0, frame_start_out once per 70224 cycles, and LY wraps 153->0.
REQ-039 Set lyc_in=5 and stat_sel_in=4'b1001 -> stat_irq_out pulses once at LY=5 dot 0, with no second pulse at that line's HBlank entry.
REQ-040 Push only 100 pixels on line 3 -> at dot 455 draw_overrun_out=1 and the line wraps to LY=4 in OAMScan.
REQ-041 Drop lcd_en_in at LY=50 dot 200, then re-raise it -> outputs are in the reset state, restart is at LY=0 dot 0 OAMScan, and frame_start_out pulses.
REQ-042 With PPU_LY153_QUIRK_EN defined and lyc_in=0 -> ly_out reads 153 for dots 0..3 of line 153, then 0, and lyc_eq_out=1 from dot 4.
